// File: rtl/instruction_register_if.sv
// instruction_register_if: bus-side signals of the SAP instruction register
//   load    active-low load strobe (sampled on rising clk)
//   enable  active-low output enable for q
//   data    DATA_W bus word to capture
//   q       OPER_W operand field returned to the bus
//   opcode  OPER_W opcode field to the control sequencer
// modports: master = bus/controller side, slave = instruction register
interface instruction_register_if #(
    parameter int DATA_W = 8,
    parameter int OPER_W = DATA_W / 2
);
    logic              load;
    logic              enable;
    logic [DATA_W-1:0] data;
    logic [OPER_W-1:0] q;
    logic [OPER_W-1:0] opcode;
    modport master (output load, enable, data, input q, opcode);
    modport slave  (input load, enable, data, output q, opcode);
endinterface

// File: rtl/instruction_register.sv
// instruction_register: SAP-class IR, captures a bus word and splits it into opcode/operand
//   clk  system clock, rising edge
//   clr  asynchronous active-low clear
//   bus  instruction_register_if.slave (load, enable, data -> q, opcode)
// Macro IR_BUS_TRISTATE_EN: when defined q floats (z) while disabled for a shared
// tri-state bus; otherwise q is driven to 0 for an OR/mux-combined bus.
module instruction_register #(
    parameter int DATA_W = 8,
    parameter int OPER_W = DATA_W / 2
) (
    input logic                   clk,
    input logic                   clr,
    instruction_register_if.slave bus
);
    logic [DATA_W-1:0] stored;
    // load is level-sensitive: every edge with load low recaptures data
    always_ff @(posedge clk or negedge clr)
        if (!clr) stored <= '0;
        else if (!bus.load) stored <= bus.data;
    assign bus.opcode = stored[DATA_W-1:OPER_W];
`ifdef IR_BUS_TRISTATE_EN
    assign bus.q = bus.enable ? {OPER_W{1'bz}} : stored[OPER_W-1:0];
`else
    assign bus.q = bus.enable ? {OPER_W{1'b0}} : stored[OPER_W-1:0];
`endif
endmodule

// File: tb/tb_instruction_register.sv
// tb_instruction_register: directed scoreboard bench for 8-bit and 16-bit instruction registers
module tb_instruction_register;
    logic clk = 1'b0;
    logic clr;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    instruction_register_if #(.DATA_W(8), .OPER_W(4)) nb ();
    instruction_register_if #(.DATA_W(16), .OPER_W(8)) wb ();
    instruction_register #(.DATA_W(8), .OPER_W(4)) dut_n (.clk(clk), .clr(clr), .bus(nb.slave));
    instruction_register #(.DATA_W(16), .OPER_W(8)) dut_w (.clk(clk), .clr(clr), .bus(wb.slave));
`ifdef IR_BUS_TRISTATE_EN
    localparam logic [7:0] QOFF = 8'hzz;
`else
    localparam logic [7:0] QOFF = 8'h00;
`endif
    logic [7:0] qoff_n;
    typedef struct {
        string      tag;
        bit         wide;
        logic [7:0] op;
        logic [7:0] q;
    } sb_t;
    sb_t sb[$];
    always @(posedge clk)
        if (clr === 1'b1 && ($isunknown(nb.load) || $isunknown(wb.load))) begin
            failures++;
            $error("FAIL xz_load load is X/Z while clr=1");
        end
    task automatic push(input string tag, input bit wide, input logic [7:0] op, input logic [7:0] q);
        sb_t e;
        e.tag = tag;
        e.wide = wide;
        e.op = op;
        e.q = q;
        sb.push_back(e);
    endtask
    task automatic check();
        sb_t e;
        logic [7:0] op_o, q_o;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL sb_empty no expected entry queued");
            return;
        end
        e = sb.pop_front();
        op_o = e.wide ? wb.opcode : {4'h0, nb.opcode};
        q_o = e.wide ? wb.q : {4'h0, nb.q};
        checks++;
        assert (op_o === e.op) else begin
            failures++;
            $error("FAIL %s opcode observed=%h expected=%h", e.tag, op_o, e.op);
        end
        checks++;
        assert (q_o === e.q) else begin
            failures++;
            $error("FAIL %s q observed=%h expected=%h", e.tag, q_o, e.q);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        qoff_n = {4'h0, QOFF[3:0]};
        clr = 1'b0;
        nb.load = 1'b1; nb.enable = 1'b0; nb.data = '0;
        wb.load = 1'b1; wb.enable = 1'b0; wb.data = '0;
        #3;
        push("reset_n", 0, 8'h00, 8'h00); check();
        push("reset_w", 1, 8'h00, 8'h00); check();
        tick();
        clr = 1'b1; nb.load = 1'b0; nb.data = 8'hF5;
        push("load_f5", 0, 8'h0F, 8'h05); tick(); check();
        nb.load = 1'b1; nb.data = 8'h55;
        push("hold_55", 0, 8'h0F, 8'h05); tick(); check();
        nb.load = 1'b0; nb.data = 8'h0F;
        push("load_0f", 0, 8'h00, 8'h0F); tick(); check();
        nb.enable = 1'b1; #1;
        push("q_off", 0, 8'h00, qoff_n); check();
        nb.enable = 1'b0; nb.load = 1'b1; #1;
        push("q_on", 0, 8'h00, 8'h0F); check();
        nb.load = 1'b0; nb.data = 8'h3C;
        push("load_3c", 0, 8'h03, 8'h0C); tick(); check();
        #2 clr = 1'b0; #1;
        push("clr_async", 0, 8'h00, 8'h00); check();
        nb.load = 1'b0; nb.data = 8'hAA;
        push("clr_wins", 0, 8'h00, 8'h00); tick(); check();
        #2 clr = 1'b1;
        push("resume_aa", 0, 8'h0A, 8'h0A); tick(); check();
        nb.data = 8'h12;
        push("level_12", 0, 8'h01, 8'h02); tick(); check();
        nb.enable = 1'b1; nb.load = 1'b1; #1;
        push("q_off_12", 0, 8'h01, qoff_n); check();
        wb.load = 1'b0; wb.data = 16'hBEEF;
        push("w_beef", 1, 8'hBE, 8'hEF); tick(); check();
        wb.load = 1'b1; wb.data = 16'h1234; wb.enable = 1'b1;
        push("w_hold_off", 1, 8'hBE, QOFF); tick(); check();
        #2 clr = 1'b0; #1;
        push("w_clr", 1, 8'h00, QOFF); check();
        clr = 1'b1;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
